// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and fetch handshake for the front end.
// Chooses between sequential fetch, branch redirect and (optionally) trap and
// return-from-trap redirects. It also tracks a fetch that is outstanding while
// instruction memory is not ready.
// Optional feature macro: TRAP_SUPPORT_EN
//   defined   : trap_req/mret_req redirect to TRAP_VECTOR/epc, and epc captures trap_pc
//   undefined : only branch_taken_e redirects, and epc stays 0
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        stall_d,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        flush_d,
  output logic        flush_e,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] epc_q, epc_d;

  logic        trap_v, mret_v, redir;
  logic [31:0] redir_tgt, seq_pc, pc_next_raw;

`ifdef TRAP_SUPPORT_EN
  assign trap_v = trap_req;
  assign mret_v = mret_req;
`else
  assign trap_v = 1'b0;
  assign mret_v = 1'b0;
  // Trap inputs are intentionally unconnected in this build.
  logic unused_trap;
  assign unused_trap = ^{trap_req, mret_req, trap_pc};
`endif

  // Redirect source and target, in priority order trap > mret > branch.
  assign redir     = trap_v | mret_v | branch_taken_e;
  assign redir_tgt = trap_v ? TRAP_VECTOR : (mret_v ? epc_q : branch_target_e);
  assign seq_pc    = pc_f + 32'd4;

  // Targets are word aligned. The low bits are dropped on every path.
  assign pc_next = {pc_next_raw[31:2], 2'b00};
  assign epc     = epc_q;

  // Next-state and output decode. Reset overrides everything so the
  // outputs stay idle while reset is held.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    epc_d       = epc_q;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_next_raw = seq_pc;
    flush_d     = 1'b0;
    flush_e     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        pc_en       = 1'b1;
        pc_next_raw = RESET_VECTOR;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (redir) begin
          pc_en       = 1'b1;
          pc_next_raw = redir_tgt;
          flush_d     = 1'b1;
          flush_e     = 1'b1;
          if (trap_v) epc_d = trap_pc;
        end else begin
          imem_req = !stall_d;
          if (!stall_d) begin
            if (imem_ready) pc_en = 1'b1;
            else            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The request stays up until memory accepts it, even under stall.
        imem_req = 1'b1;
        if (redir) begin
          pending_d = redir_tgt;
          flush_d   = 1'b1;
          flush_e   = 1'b1;
          state_d   = S_HOLD;
          if (trap_v) epc_d = trap_pc;
        end else if (imem_ready) begin
          // When stalled, the PC is not advanced, so the same address is fetched again.
          pc_en   = !stall_d;
          state_d = S_RUN;
        end
      end
      S_HOLD: begin
        // Drain the wrong-path fetch, then jump to the saved target.
        imem_req = 1'b1;
        if (redir) begin
          pending_d = redir_tgt;
          flush_d   = 1'b1;
          flush_e   = 1'b1;
          if (trap_v) epc_d = trap_pc;
          if (imem_ready) begin
            pc_en       = 1'b1;
            pc_next_raw = redir_tgt;
            state_d     = S_RUN;
          end
        end else if (imem_ready) begin
          pc_en       = 1'b1;
          pc_next_raw = pending_q;
          flush_d     = 1'b1;
          state_d     = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (reset) begin
      state_d     = S_BOOT;
      pending_d   = 32'h0;
      epc_d       = 32'h0;
      imem_req    = 1'b0;
      pc_en       = 1'b0;
      pc_next_raw = RESET_VECTOR;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
    end
  end

  // State, pending target and saved trap PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      pending_q <= 32'h0;
      epc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL expose parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL expose parameter TRAP_VECTOR, default 32'h0000_0100, the redirect target on trap.
REQ-003 The block SHALL provide ports, one per line, name direction width meaning:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- pc_f  in  32  current fetch PC fed back from the program counter register
- stall_d  in  1  decode-stage hazard stall
- branch_taken_e  in  1  branch/jump resolved taken in execute
- branch_target_e  in  32  execute-stage redirect target
- trap_req  in  1  trap request
- trap_pc  in  32  PC of the trapping instruction
- mret_req  in  1  return-from-trap request
- imem_ready  in  1  instruction memory accepts the current request
- imem_req  out  1  fetch request at address pc_f
- pc_next  out  32  next-PC value for the program counter register
- pc_en  out  1  load enable for the program counter register
- flush_d  out  1  flush the fetch/decode pipeline register
- flush_e  out  1  flush the decode/execute pipeline register
- epc  out  32  saved trap PC

Function
REQ-004 The block SHALL implement states BOOT, RUN, WAIT and HOLD.
REQ-005 Redirect priority SHALL be trap_req > mret_req > branch_taken_e, with targets TRAP_VECTOR, epc and branch_target_e.
REQ-006 pc_next[1:0] SHALL always be 2'b00; target bits [1:0] are discarded.
REQ-007 Sequential pc_next SHALL be pc_f+4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-008 BOOT SHALL last exactly one cycle: imem_req=0, pc_en=1, pc_next=RESET_VECTOR, then RUN.
REQ-009 In RUN, when a redirect is present, the block SHALL drive imem_req=0, pc_en=1, pc_next=target, flush_d=1, flush_e=1, and stay in RUN.
REQ-010 In RUN with no redirect, imem_req SHALL equal !stall_d.
- On imem_req&imem_ready: pc_en=1, pc_next=pc_f+4, stay in RUN.
- On imem_req&!imem_ready: pc_en=0, go to WAIT.
REQ-011 In WAIT, imem_req SHALL be held at 1 with pc_f unchanged, regardless of stall_d.
- On imem_ready: pc_en=!stall_d, pc_next=pc_f+4, go to RUN. A fetch accepted under stall is refetched.
REQ-012 In WAIT, a redirect SHALL latch its target into a pending register, pulse flush_d=1 and flush_e=1, keep pc_en=0, and go to HOLD.
REQ-013 In HOLD, imem_req SHALL stay at 1.
- On imem_ready: pc_en=1, pc_next=pending, flush_d=1, go to RUN.
- A new redirect in HOLD SHALL overwrite pending and pulse flush_d/flush_e. If it coincides with imem_ready, the new target SHALL be loaded directly.
REQ-014 pc_en and all redirect outputs SHALL be combinational from state and inputs; pending and epc SHALL be registered.
REQ-015 flush_d and flush_e SHALL be single-cycle pulses per redirect event.

Reset
REQ-016 Reset SHALL force state=BOOT, pending=0 and epc=0.
REQ-017 While reset is high, imem_req, pc_en, flush_d and flush_e SHALL be 0 and pc_next SHALL be RESET_VECTOR.
REQ-018 Reset asserted in WAIT or HOLD SHALL abandon the outstanding fetch and pending target with no further pc_en pulse.

Configuration
REQ-019 With TRAP_SUPPORT_EN defined, trap_req and mret_req SHALL act per REQ-005, and epc SHALL load trap_pc on every cycle in which a trap redirect is taken.
REQ-020 Without TRAP_SUPPORT_EN, trap_req, trap_pc and mret_req SHALL be ignored, epc SHALL be constant 0, and only branch_taken_e SHALL redirect.

Verification
REQ-021 Release reset with imem_ready=1 and stall_d=0 -> BOOT loads 32'h0, then pc_en every cycle with pc_next 4, 8, 12.
REQ-022 pc_f=32'h10, imem_ready low for 3 cycles -> imem_req held 1 and pc_en=0 for 3 cycles, then pc_next=32'h14.
REQ-023 In WAIT at pc_f=32'h20, branch to 32'h80 -> flush pulse, HOLD; on imem_ready, pc_next=32'h80 and flush_d=1.
REQ-024 RUN, same cycle trap_req and branch_taken_e, trap_pc=32'h44 -> pc_next=32'h100 and epc=32'h44; a later mret_req -> pc_next=32'h44.
REQ-025 pc_f=32'hFFFF_FFFC accepted -> pc_next=32'h0. branch_target_e=32'h103 -> pc_next=32'h100.
REQ-026 Assert reset during HOLD with pending 32'h80 -> outputs idle, pending and epc cleared, restart from BOOT at 32'h0.
